// File: rtl/forward_hazard_unit_if.sv
// forward_hazard_unit_if
//   Groups the ID-stage tag/source bus, the pipeline control inputs and the
//   hazard/forward decisions of forward_hazard_unit.
//   master : pipeline side (drives ID info and freeze/flush, reads decisions)
//   slave  : forward_hazard_unit itself
//   Signals:
//     id_valid, id_regWEN, id_writeReg[REGW], id_isLoad  ID destination tag
//     id_rsel[NREAD*REGW], id_ruse[NREAD]                ID source registers
//     pipe_stall, id_flush                               pipeline control
//     hazard_stall, fwd_sel[NREAD*SELW]                  decisions
interface forward_hazard_unit_if #(
  parameter int unsigned NREAD = 2,
  parameter int unsigned REGW  = 5,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned SELW  = $clog2(DEPTH + 1)
);
  logic                    id_valid;
  logic                    id_regWEN;
  logic [REGW-1:0]         id_writeReg;
  logic                    id_isLoad;
  logic [NREAD*REGW-1:0]   id_rsel;
  logic [NREAD-1:0]        id_ruse;
  logic                    pipe_stall;
  logic                    id_flush;
  logic                    hazard_stall;
  logic [NREAD*SELW-1:0]   fwd_sel;

  modport master (
    output id_valid, id_regWEN, id_writeReg, id_isLoad, id_rsel, id_ruse,
    output pipe_stall, id_flush,
    input  hazard_stall, fwd_sel
  );

  modport slave (
    input  id_valid, id_regWEN, id_writeReg, id_isLoad, id_rsel, id_ruse,
    input  pipe_stall, id_flush,
    output hazard_stall, fwd_sel
  );
endinterface

// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit
//   Forwarding and load-use hazard unit. Keeps a shift register of
//   destination tags (valid, write-enable, dest, load) that moves in
//   lock-step with the pipeline latches (stage 1 = ID/EX, 2 = EX/MEM, ...)
//   plus the source registers of the instruction sitting in ID/EX.
//   From these it derives a decode stall request and per-port forward
//   selects for the EX instruction.
// Ports:
//   CLK, RST      clock, asynchronous active-high reset
//   bus (slave)   ID tag/sources, pipe_stall, id_flush in;
//                 hazard_stall, fwd_sel out (0 = regfile, k = stage k)
//   stall_cycles, fwd_events [31:0]  saturating counters, present only when
//                 FWD_HAZARD_STATS_EN is defined
module forward_hazard_unit #(
  parameter int unsigned NREAD    = 2,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned REGW     = 5,
  parameter int unsigned LOAD_RDY = 3,
  parameter int unsigned SELW     = $clog2(DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  forward_hazard_unit_if.slave  bus
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           fwd_events
`endif
);

  // Ready stage of a producer; anything beyond the tracked depth is
  // treated as ready at the last tracked stage.
  localparam int unsigned LD_R  = (LOAD_RDY > DEPTH) ? DEPTH : LOAD_RDY;
  localparam int unsigned ALU_R = 2;

  logic [DEPTH:1]        tag_v;
  logic [DEPTH:1]        tag_wen;
  logic [DEPTH:1]        tag_ld;
  logic [REGW-1:0]       tag_dest [1:DEPTH];

  logic                  ex_v;
  logic [NREAD*REGW-1:0] ex_rsel;
  logic [NREAD-1:0]      ex_ruse;

  logic                  stall_any;
  logic                  advance;
  logic [NREAD*SELW-1:0] fwd_sel_c;

  function automatic logic tag_hit(input logic v, input logic wen,
                                   input logic [REGW-1:0] dest,
                                   input logic [REGW-1:0] r);
    return v && wen && (dest == r) && (r != '0);
  endfunction

  // Decode stall: only the youngest matching producer matters per port.
  always_comb begin
    logic [REGW-1:0] r;
    logic            found;
    logic            hit_ld;
    int unsigned     hit_k;
    stall_any = 1'b0;
    r         = '0;
    found     = 1'b0;
    hit_ld    = 1'b0;
    hit_k     = 0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      r      = bus.id_rsel[i*REGW +: REGW];
      found  = 1'b0;
      hit_ld = 1'b0;
      hit_k  = 0;
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        if (!found && tag_hit(tag_v[k], tag_wen[k], tag_dest[k], r)) begin
          found  = 1'b1;
          hit_k  = k;
          hit_ld = tag_ld[k];
        end
      end
      if (bus.id_ruse[i] && found && ((hit_k + 1) < (hit_ld ? LD_R : ALU_R)))
        stall_any = 1'b1;
    end
  end

  assign bus.hazard_stall = bus.id_valid && stall_any;
  assign advance          = bus.id_valid && !bus.hazard_stall && !bus.id_flush;

  // EX forward select: youngest matching stage from 2 upward.
  always_comb begin
    logic [REGW-1:0] r;
    logic            done;
    fwd_sel_c = '0;
    r         = '0;
    done      = 1'b0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      r    = ex_rsel[i*REGW +: REGW];
      done = 1'b0;
      for (int unsigned k = 2; k <= DEPTH; k++) begin
        if (!done && ex_v && ex_ruse[i] &&
            tag_hit(tag_v[k], tag_wen[k], tag_dest[k], r)) begin
          fwd_sel_c[i*SELW +: SELW] = SELW'(k);
          done = 1'b1;
        end
      end
    end
  end

  assign bus.fwd_sel = fwd_sel_c;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tag_v   <= '0;
      tag_wen <= '0;
      tag_ld  <= '0;
      for (int unsigned k = 1; k <= DEPTH; k++) tag_dest[k] <= '0;
      ex_v    <= 1'b0;
      ex_rsel <= '0;
      ex_ruse <= '0;
    end else if (!bus.pipe_stall) begin
      for (int unsigned k = 2; k <= DEPTH; k++) begin
        tag_v[k]    <= tag_v[k-1];
        tag_wen[k]  <= tag_wen[k-1];
        tag_ld[k]   <= tag_ld[k-1];
        tag_dest[k] <= tag_dest[k-1];
      end
      // A stalled or flushed ID enters as a bubble; only v needs clearing.
      tag_v[1]    <= advance;
      tag_wen[1]  <= bus.id_regWEN;
      tag_ld[1]   <= bus.id_isLoad;
      tag_dest[1] <= bus.id_writeReg;
      ex_v        <= advance;
      ex_rsel     <= bus.id_rsel;
      ex_ruse     <= bus.id_ruse;
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] fwd_cnt;
  logic [32:0] fe_sum;

  always_comb begin
    fwd_cnt = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      if (fwd_sel_c[i*SELW +: SELW] != '0) fwd_cnt = fwd_cnt + 32'd1;
    end
  end

  assign fe_sum = {1'b0, fwd_events} + {1'b0, fwd_cnt};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cycles <= '0;
      fwd_events   <= '0;
    end else if (!bus.pipe_stall) begin
      if (bus.hazard_stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      fwd_events <= fe_sum[32] ? '1 : fe_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
module tb_forward_hazard_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       id_valid, id_regWEN, id_isLoad, pipe_stall, id_flush;
  logic [4:0] id_writeReg;
  logic [9:0] id_rsel;
  logic [1:0] id_ruse;

  forward_hazard_unit_if #(.NREAD(2), .REGW(5), .DEPTH(3)) b3 ();
  forward_hazard_unit_if #(.NREAD(2), .REGW(5), .DEPTH(4)) b4 ();

  assign b3.id_valid    = id_valid;
  assign b3.id_regWEN   = id_regWEN;
  assign b3.id_writeReg = id_writeReg;
  assign b3.id_isLoad   = id_isLoad;
  assign b3.id_rsel     = id_rsel;
  assign b3.id_ruse     = id_ruse;
  assign b3.pipe_stall  = pipe_stall;
  assign b3.id_flush    = id_flush;
  assign b4.id_valid    = id_valid;
  assign b4.id_regWEN   = id_regWEN;
  assign b4.id_writeReg = id_writeReg;
  assign b4.id_isLoad   = id_isLoad;
  assign b4.id_rsel     = id_rsel;
  assign b4.id_ruse     = id_ruse;
  assign b4.pipe_stall  = pipe_stall;
  assign b4.id_flush    = id_flush;

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] sc3, fe3, sc4, fe4;
`endif

  forward_hazard_unit #(.NREAD(2), .DEPTH(3), .REGW(5), .LOAD_RDY(3)) u_dut3 (
    .CLK (clk),
    .RST (rst),
    .bus (b3)
`ifdef FWD_HAZARD_STATS_EN
    ,
    .stall_cycles (sc3),
    .fwd_events   (fe3)
`endif
  );

  forward_hazard_unit #(.NREAD(2), .DEPTH(4), .REGW(5), .LOAD_RDY(4)) u_dut4 (
    .CLK (clk),
    .RST (rst),
    .bus (b4)
`ifdef FWD_HAZARD_STATS_EN
    ,
    .stall_cycles (sc4),
    .fwd_events   (fe4)
`endif
  );

  typedef struct {
    int    cyc;
    string name;
    int    which;
    int    st;
    int    f0;
    int    f1;
    bit    chk_stats;
    int    sc;
    int    fe;
  } exp_t;

  exp_t q[$];
  int compared   = 0;
  int mismatched = 0;

  task automatic cmp(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // Monitor: checks every expectation queued for the current cycle.
  exp_t m;
  int   a_st, a_f0, a_f1;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m = q.pop_front();
      if (m.cyc < cyc) begin
        compared++;
        mismatched++;
        $display("FAIL %s stale: checked at cycle %0d, expected at cycle %0d", m.name, cyc, m.cyc);
      end else if (m.chk_stats) begin
`ifdef FWD_HAZARD_STATS_EN
        cmp({m.name, "/stall_cycles"}, int'(sc3), m.sc);
        cmp({m.name, "/fwd_events"}, int'(fe3), m.fe);
`endif
      end else begin
        if (m.which == 0) begin
          a_st = int'(b3.hazard_stall);
          a_f0 = int'(b3.fwd_sel[1:0]);
          a_f1 = int'(b3.fwd_sel[3:2]);
        end else begin
          a_st = int'(b4.hazard_stall);
          a_f0 = int'(b4.fwd_sel[2:0]);
          a_f1 = int'(b4.fwd_sel[5:3]);
        end
        cmp({m.name, "/hazard_stall"}, a_st, m.st);
        cmp({m.name, "/fwd_sel0"}, a_f0, m.f0);
        cmp({m.name, "/fwd_sel1"}, a_f1, m.f1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic wen, input int dest, input logic ld,
                        input int r0, input int r1, input logic u0, input logic u1);
    id_valid    = v;
    id_regWEN   = wen;
    id_writeReg = dest[4:0];
    id_isLoad   = ld;
    id_rsel     = {r1[4:0], r0[4:0]};
    id_ruse     = {u1, u0};
  endtask

  task automatic idle();
    set_id(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic exp_out(input string name, input int which, input int st, input int f0, input int f1);
    exp_t e;
    e.cyc = cyc; e.name = name; e.which = which;
    e.st = st; e.f0 = f0; e.f1 = f1;
    e.chk_stats = 1'b0; e.sc = 0; e.fe = 0;
    q.push_back(e);
  endtask

`ifdef FWD_HAZARD_STATS_EN
  task automatic exp_stats(input string name, input int sc, input int fe);
    exp_t e;
    e.cyc = cyc; e.name = name; e.which = 0;
    e.st = 0; e.f0 = 0; e.f1 = 0;
    e.chk_stats = 1'b1; e.sc = sc; e.fe = fe;
    q.push_back(e);
  endtask
`endif

  initial begin
    rst = 1'b1; pipe_stall = 1'b0; id_flush = 1'b0;
    idle();
    tick();
    set_id(1, 0, 0, 0, 8, 8, 1, 1);
    exp_out("in_reset", 0, 0, 0, 0);
    exp_out("in_reset4", 1, 0, 0, 0);
    tick(); rst = 1'b0;

    // writers to r8 fill the pipeline, then reset strikes while frozen
    set_id(1, 1, 8, 0, 8, 0, 1, 0); exp_out("r8_c1", 0, 0, 0, 0); tick();
    set_id(1, 1, 8, 0, 8, 0, 1, 0); exp_out("r8_c2", 0, 0, 0, 0); tick();
    set_id(1, 1, 8, 1, 8, 0, 1, 0); exp_out("r8_c3", 0, 0, 2, 0); tick();
    set_id(1, 1, 9, 0, 8, 0, 1, 0); pipe_stall = 1'b1;
    exp_out("r8_prerst", 0, 1, 2, 0); tick();
    rst = 1'b1;
    exp_out("r8_async_rst", 0, 0, 0, 0); tick();
    rst = 1'b0; pipe_stall = 1'b0;
    exp_out("r8_after_rst", 0, 0, 0, 0); tick();
    idle(); exp_out("r8_ex_after_rst", 0, 0, 0, 0); tick();

    // ALU producer: no stall, forward from 2 then 3
    set_id(1, 1, 3, 0, 1, 2, 1, 1);   exp_out("alu_add", 0, 0, 0, 0); tick();
    set_id(1, 1, 4, 0, 3, 3, 1, 1);   exp_out("alu_sub", 0, 0, 0, 0); tick();
    set_id(1, 1, 10, 0, 3, 4, 1, 1);  exp_out("alu_fwd2", 0, 0, 2, 2); tick();
    idle();                           exp_out("alu_fwd3", 0, 0, 3, 2); tick();

    // load-use: one stall, then forward from stage 3
    set_id(1, 1, 5, 1, 0, 0, 0, 0);   exp_out("ld_lw", 0, 0, 0, 0); tick();
    set_id(1, 1, 6, 0, 5, 1, 1, 1);   exp_out("ld_stall", 0, 1, 0, 0); tick();
    exp_out("ld_release", 0, 0, 0, 0); tick();
    idle();                           exp_out("ld_fwd3", 0, 0, 3, 0); tick();

    // r0 writers everywhere, unused port
    set_id(1, 1, 0, 0, 0, 0, 0, 0);   exp_out("r0_a", 0, 0, 0, 0); tick();
    set_id(1, 1, 0, 1, 0, 0, 0, 0);   exp_out("r0_b", 0, 0, 0, 0); tick();
    set_id(1, 1, 0, 0, 0, 0, 0, 0);   exp_out("r0_c", 0, 0, 0, 0); tick();
    set_id(1, 0, 0, 0, 0, 0, 1, 1);   exp_out("r0_read", 0, 0, 0, 0); tick();
    set_id(1, 1, 7, 1, 0, 0, 0, 0);   exp_out("r0_ex", 0, 0, 0, 0); tick();
    set_id(1, 1, 11, 0, 1, 7, 1, 0);  exp_out("unused_id", 0, 0, 0, 0); tick();
    idle();                           exp_out("unused_ex", 0, 0, 0, 0); tick();

    // younger load shadows older ALU write to same register
    set_id(1, 1, 9, 0, 0, 0, 0, 0);   exp_out("yng_add", 0, 0, 0, 0); tick();
    set_id(1, 1, 9, 1, 0, 0, 0, 0);   exp_out("yng_lw", 0, 0, 0, 0); tick();
    set_id(1, 1, 12, 0, 9, 0, 1, 0);  exp_out("yng_stall", 0, 1, 0, 0); tick();
    exp_out("yng_release", 0, 0, 0, 0); tick();
    idle();                           exp_out("yng_fwd3", 0, 0, 3, 0); tick();

    // freeze during a stall, flush during the stall cycle
    set_id(1, 1, 13, 1, 0, 0, 0, 0);  exp_out("frz_lw", 0, 0, 0, 0); tick();
    set_id(1, 1, 14, 0, 13, 13, 1, 1); pipe_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_out("frz_hold", 0, 1, 0, 0); tick();
    end
    pipe_stall = 1'b0; id_flush = 1'b1;
    exp_out("frz_flush_stall", 0, 1, 0, 0); tick();
    id_flush = 1'b0;
    exp_out("frz_after", 0, 0, 0, 0); tick();
    set_id(1, 1, 15, 1, 0, 0, 0, 0); id_flush = 1'b1;
    exp_out("frz_fwd3", 0, 0, 3, 3); tick();
    id_flush = 1'b0;
    set_id(1, 1, 16, 0, 15, 0, 1, 0); exp_out("flush_gone", 0, 0, 0, 0); tick();
    idle();                           exp_out("flush_ex", 0, 0, 0, 0);
`ifdef FWD_HAZARD_STATS_EN
    exp_stats("stats", 3, 8);
`endif
    tick();

    // DEPTH=4, LOAD_RDY=4: two stall cycles, forward from stage 4
    rst = 1'b1; idle();
    exp_out("d4_rst", 1, 0, 0, 0); tick();
    rst = 1'b0;
    set_id(1, 1, 5, 1, 0, 0, 0, 0);   exp_out("d4_lw", 1, 0, 0, 0); tick();
    set_id(1, 1, 6, 0, 5, 1, 1, 1);   exp_out("d4_stall1", 1, 1, 0, 0); tick();
    exp_out("d4_stall2", 1, 1, 0, 0); tick();
    exp_out("d4_release", 1, 0, 0, 0); tick();
    idle();                           exp_out("d4_fwd4", 1, 0, 4, 0); tick();

    repeat (3) tick();
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL pending_checks: %0d left unchecked, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/forward_hazard_unit.md
# forward_hazard_unit

Parametrised forwarding and load-use hazard unit for the pipelined datapath. It keeps its own shift register of destination tags (valid, write-enable, destination, load flag) that advances in lock-step with the pipeline latches. Two decisions are derived from this tag pipeline: a decode-stage stall request when a producer's result cannot reach the consumer in time, and per-read-port forward selects for the instruction in EX. Read-port count, tracked depth and load latency are generic.

## Interface
Parameters:
- NREAD, 2: number of source-register read ports per instruction.
- DEPTH, 3: tracked latch stages. Stage 1 = ID/EX, 2 = EX/MEM, 3 = MEM/WB, and so on.
- REGW, 5: register index width.
- LOAD_RDY, 3: first stage at which a load result is forwardable. Non-load results are forwardable from stage 2. Legal range 2..DEPTH.
- SELW, $clog2(DEPTH+1): forward-select width (derived).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_regWEN  in  1  ID instruction writes a register.
- id_writeReg  in  REGW  ID destination register.
- id_isLoad  in  1  ID instruction is a load.
- id_rsel  in  NREAD*REGW  ID source registers; port i occupies bits [i*REGW +: REGW].
- id_ruse  in  NREAD  port i is actually read by the ID instruction.
- pipe_stall  in  1  global freeze (cache miss); all state holds.
- id_flush  in  1  squash the ID instruction; a bubble enters stage 1.
- hazard_stall  out  1  hold PC and IF/ID this cycle; a bubble enters ID/EX.
- fwd_sel  out  NREAD*SELW  per EX read port: 0 = register file, k = stage k (2..DEPTH).

## Operation
- Each tag entry holds {v, wen, dest, ld}. The EX slot holds {v, rsel[NREAD], ruse[NREAD]} for the instruction sitting in ID/EX.
- A stage k entry matches register r when v && wen && dest == r && r != 0. Register 0 never matches.
- **Stall (combinational, ID):**
  - For each used ID port, find the youngest matching stage k (smallest k).
  - The producer's ready stage R is LOAD_RDY if ld is set, else 2.
  - The port stalls if k+1 < R.
  - hazard_stall is the OR over all ports, gated by id_valid.
  - An older match is ignored when a younger match exists.
- **Forward (combinational, EX):**
  - For each EX-slot port with v && ruse, fwd_sel = the smallest k in 2..DEPTH whose entry matches.
  - fwd_sel = 0 if there is no match, the port is unused, or the slot is invalid.
- **Advance (edge, when !pipe_stall):**
  - Stage k+1 <= stage k for k = 1..DEPTH-1; the stage DEPTH entry is discarded.
  - Stage 1 <= ID tag and the EX slot <= ID sources, when id_valid && !hazard_stall && !id_flush. Otherwise both receive a bubble (v = 0).
- When pipe_stall = 1, nothing changes and outputs remain consistent with the held state.
- An entry whose R > DEPTH is treated as R = DEPTH.

## Timing
- Reset: all tag entries and the EX slot are invalid. hazard_stall = 0, fwd_sel = 0, and counters are 0 when compiled in. Reset asserted mid-operation clears in-flight tags immediately, without waiting for a clock edge.
- hazard_stall and fwd_sel are combinational from current state and ID inputs; there is no extra latency.
- A load followed by a dependent instruction stalls for LOAD_RDY-2 cycles (1 with defaults), after which the consumer forwards from stage LOAD_RDY.
- An ALU producer followed by a dependent instruction causes no stall; the consumer forwards from stage 2 in the next cycle.
- Simultaneous events:
  - pipe_stall with hazard_stall: hazard_stall stays asserted and nothing moves.
  - id_flush with hazard_stall: a single bubble is inserted.

## Configuration
- FWD_HAZARD_STATS_EN defined: two additional outputs, stall_cycles [31:0] and fwd_events [31:0], both saturating and cleared by RST.
  - stall_cycles increments each edge on which hazard_stall && !pipe_stall.
  - fwd_events increments by the number of EX ports with fwd_sel != 0, on edges where !pipe_stall.
- Macro undefined: the counters and their ports are absent.

## Test plan
- Reset is asserted while stages hold valid writers to r8. After release, an ID read of r8 gives hazard_stall = 0, and in EX fwd_sel = 0.
- add r3 → sub r4,r3,r3 back-to-back: no stall; in EX both ports have fwd_sel = 2. One cycle later, a dependent in EX sees fwd_sel = 3.
- lw r5 → add r6,r5,r1: hazard_stall = 1 for exactly 1 cycle, then EX port 0 fwd_sel = 3 and port 1 fwd_sel = 0. With LOAD_RDY = 4 and DEPTH = 4, the stall lasts 2 cycles.
- Writes to r0 in every stage: no stall and all fwd_sel = 0. A producer to r7 with the consumer's id_ruse[1] = 0 on that port: no stall.
- add r9 then lw r9 then a consumer of r9: the younger load determines the outcome, giving 1 stall cycle and then forward from stage 3 (not stage 2).
- pipe_stall held for 4 cycles mid-stall: hazard_stall stays 1 and the tags are unchanged. id_flush during the stall cycle inserts one bubble. With FWD_HAZARD_STATS_EN defined, stall_cycles increments only on non-frozen edges.
